// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus between fetch_sequencer (master) and imem (slave).
//  req   : fetch request, held until ack
//  addr  : fetch address, stable while req
//  ack   : transfer completes on an edge with req & ack
//  rdata : instruction word, valid with ack
//  err   : bus error, valid with ack
interface fetch_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, input  ack, rdata, err);
  modport slave  (input  req, addr, output ack, rdata, err);
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control.
//  Computes pc_next for program_counter, runs the imem req/ack handshake,
//  buffers one fetched word for decode, applies redirects, squashes stale
//  fetches and vectors faults to TRAP_VECTOR.
// Ports:
//  clk, reset        falling-edge clock, synchronous active-high reset
//  pc_cur / pc_next  program_counter output / combinational next PC
//  imem              fetch bus (master side)
//  redirect_*        taken branch/jump and its target
//  stall,instr_ready decode back-pressure
//  instr_*           buffered word to decode
//  fault_*           registered one-cycle fault pulse; cause/pc sticky
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc_cur,
  output logic [31:0]              pc_next,
  fetch_sequencer_if.master        imem,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_target,
  input  logic                     stall,
  input  logic                     instr_ready,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic                     fault_valid,
  output logic [1:0]               fault_cause,
  output logic [31:0]              fault_pc
);

  typedef enum logic [1:0] {BOOT, FETCH, DELIVER} state_e;

  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        fault_valid_q, fault_valid_d;
  logic [1:0]  fault_cause_q, fault_cause_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  // Misaligned redirect targets are vectored to the trap handler.
  logic        redir_bad;
  logic [31:0] redir_pc;
  assign redir_bad = |redirect_target[1:0];
  assign redir_pc  = redir_bad ? TRAP_VECTOR : redirect_target;

  always_comb begin
    state_d       = state_q;
    kill_d        = kill_q;
    fetch_addr_d  = fetch_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fault_valid_d = 1'b0;
    fault_cause_d = fault_cause_q;
    fault_pc_d    = fault_pc_q;
    pc_next       = pc_cur;

    case (state_q)
      BOOT: begin
        pc_next      = RESET_VECTOR;
        fetch_addr_d = RESET_VECTOR;
        state_d      = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_next = redir_pc;
          if (redir_bad) begin
            fault_valid_d = 1'b1;
            fault_cause_d = 2'b10;
            fault_pc_d    = redirect_target;
          end
          // Without ack the request must complete at its old address, so
          // remember to discard it; with ack it is dropped right now.
          if (imem.ack) begin
            kill_d       = 1'b0;
            fetch_addr_d = redir_pc;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem.ack) begin
          if (kill_q) begin
            // pc_cur already holds the redirected PC; reissue there.
            kill_d       = 1'b0;
            fetch_addr_d = pc_cur;
          end else if (imem.err) begin
            pc_next       = TRAP_VECTOR;
            fetch_addr_d  = TRAP_VECTOR;
            fault_valid_d = 1'b1;
            fault_cause_d = 2'b01;
            fault_pc_d    = fetch_addr_q;
          end else begin
            pc_next    = fetch_addr_q + 32'd4;
            instr_d    = imem.rdata;
            instr_pc_d = fetch_addr_q;
            state_d    = DELIVER;
          end
        end
      end
      DELIVER: begin
        if (redirect_valid) begin
          pc_next      = redir_pc;
          fetch_addr_d = redir_pc;
          state_d      = FETCH;
          if (redir_bad) begin
            fault_valid_d = 1'b1;
            fault_cause_d = 2'b10;
            fault_pc_d    = redirect_target;
          end
        end else if (instr_ready && !stall) begin
          fetch_addr_d = pc_cur;
          state_d      = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      kill_q        <= 1'b0;
      fetch_addr_q  <= RESET_VECTOR;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fault_valid_q <= 1'b0;
      fault_cause_q <= '0;
      fault_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      fetch_addr_q  <= fetch_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fault_valid_q <= fault_valid_d;
      fault_cause_q <= fault_cause_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  assign imem.req    = (state_q == FETCH);
  assign imem.addr   = fetch_addr_q;
  assign instr_valid = (state_q == DELIVER);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fault_valid = fault_valid_q;
  assign fault_cause = fault_cause_q;
  assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the fetch unit
// (held word, stale in-flight fetch, outstanding address, program counter).
module tb_fetch_sequencer;
  localparam logic [31:0] RV = 32'h0000_0200;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur, pc_next;
  logic        redirect_valid, stall, instr_ready;
  logic [31:0] redirect_target;
  logic        instr_valid, fault_valid;
  logic [31:0] instr, instr_pc, fault_pc;
  logic [1:0]  fault_cause;

  always #5 clk = ~clk;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next), .imem(bus),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .stall(stall), .instr_ready(instr_ready), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .fault_valid(fault_valid),
    .fault_cause(fault_cause), .fault_pc(fault_pc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model of the fetch unit.
  bit          m_boot = 1'b1;   // waiting to launch the first fetch
  bit          m_word;          // a word is held for decode
  bit          m_stale;         // outstanding fetch is to be discarded
  logic [31:0] m_addr, m_instr, m_ipc, m_fpc, m_pc;
  bit          m_fv;
  logic [1:0]  m_fc;

  // One clock: drive inputs after rising edge, check, state moves on falling edge.
  task automatic step(input bit rst, input bit ack, input bit err, input bit rv,
                      input bit st, input bit rdy,
                      input logic [31:0] rdata, input logic [31:0] rt);
    bit          n_boot, n_word, n_stale, n_fv, tgt_bad;
    logic [31:0] n_addr, n_instr, n_ipc, n_fpc, e_pn, tgt;
    logic [1:0]  n_fc;
    @(posedge clk);
    reset = rst; bus.ack = ack; bus.err = err; bus.rdata = rdata;
    redirect_valid = rv; redirect_target = rt; stall = st; instr_ready = rdy;
    pc_cur = m_pc;
    #1;
    n_boot = m_boot; n_word = m_word; n_stale = m_stale; n_addr = m_addr;
    n_instr = m_instr; n_ipc = m_ipc; n_fv = 1'b0; n_fc = m_fc; n_fpc = m_fpc;
    e_pn = m_pc;
    tgt_bad = (rt % 4) != 0;
    tgt = tgt_bad ? TV : rt;
    if (m_boot) begin
      e_pn = RV; n_boot = 1'b0; n_addr = RV;
    end else if (rv) begin
      e_pn = tgt;
      if (tgt_bad) begin n_fv = 1'b1; n_fc = 2'd2; n_fpc = rt; end
      if (m_word) begin n_word = 1'b0; n_addr = tgt; end
      else if (ack) begin n_stale = 1'b0; n_addr = tgt; end
      else n_stale = 1'b1;
    end else if (m_word) begin
      if (rdy && !st) begin n_word = 1'b0; n_addr = m_pc; end
    end else if (ack) begin
      if (m_stale) begin n_stale = 1'b0; n_addr = m_pc; end
      else if (err) begin
        e_pn = TV; n_addr = TV; n_fv = 1'b1; n_fc = 2'd1; n_fpc = m_addr;
      end else begin
        e_pn = m_addr + 32'd4; n_word = 1'b1; n_instr = rdata; n_ipc = m_addr;
      end
    end
    if (!rst) begin
      chk("pc_next",     pc_next,     e_pn);
      chk("imem_req",    {31'd0, bus.req}, {31'd0, !m_boot && !m_word});
      chk("imem_addr",   bus.addr,    m_addr);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_word});
      chk("instr",       instr,       m_instr);
      chk("instr_pc",    instr_pc,    m_ipc);
      chk("fault_valid", {31'd0, fault_valid}, {31'd0, m_fv});
      chk("fault_cause", {30'd0, fault_cause}, {30'd0, m_fc});
      chk("fault_pc",    fault_pc,    m_fpc);
    end
    @(negedge clk);
    if (rst) begin
      m_boot = 1'b1; m_word = 1'b0; m_stale = 1'b0; m_addr = RV; m_instr = '0;
      m_ipc = '0; m_fv = 1'b0; m_fc = '0; m_fpc = '0; m_pc = '0;
    end else begin
      m_boot = n_boot; m_word = n_word; m_stale = n_stale; m_addr = n_addr;
      m_instr = n_instr; m_ipc = n_ipc; m_fv = n_fv; m_fc = n_fc; m_fpc = n_fpc;
      m_pc = e_pn;
    end
  endtask

  initial begin
    reset = 1'b1; bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = '0;
    redirect_valid = 1'b0; redirect_target = '0; stall = 1'b0; instr_ready = 1'b0;
    pc_cur = '0; m_pc = '0; m_addr = RV; m_instr = '0; m_ipc = '0; m_fpc = '0;
    m_fc = '0; m_fv = 1'b0; m_word = 1'b0; m_stale = 1'b0;

    // reset, boot, first fetch
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_req",   {31'd0, bus.req}, 32'd0);
    chk("rst_fault", {31'd0, fault_valid}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);                         // BOOT
    #1;
    chk("boot_addr", bus.addr, 32'h200);
    step(0, 0, 0, 0, 0, 1, 0, 0);                         // waiting for ack
    step(0, 1, 0, 0, 0, 1, 32'h0050_0093, 0);             // ack
    #1;
    chk("t2_valid", {31'd0, instr_valid}, 32'd1);
    chk("t2_instr", instr, 32'h0050_0093);
    chk("t2_ipc",   instr_pc, 32'h200);
    // stalled delivery, then consume
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("t3_addr", bus.addr, 32'h204);
    // redirect with request outstanding, ack two cycles later
    step(0, 0, 0, 1, 0, 1, 0, 32'h400);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 32'hdead_beef, 0);
    #1;
    chk("t4_addr", bus.addr, 32'h400);
    chk("t4_drop", {31'd0, instr_valid}, 32'd0);
    step(0, 1, 0, 0, 0, 0, 32'h1234_5678, 0);             // deliver word at 0x400
    // misaligned redirect in DELIVER
    step(0, 0, 0, 1, 0, 0, 0, 32'h402);
    #1;
    chk("t5_fv",    {31'd0, fault_valid}, 32'd1);
    chk("t5_cause", {30'd0, fault_cause}, 32'd2);
    chk("t5_fpc",   fault_pc, 32'h402);
    chk("t5_addr",  bus.addr, TV);
    // redirect to 0x300 with simultaneous ack, then bus error there
    step(0, 1, 1, 1, 0, 0, 0, 32'h300);
    step(0, 1, 1, 0, 0, 1, 0, 0);
    #1;
    chk("t6_cause", {30'd0, fault_cause}, 32'd1);
    chk("t6_fpc",   fault_pc, 32'h300);
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);                         // reset mid-FETCH
    #1;
    chk("t6_rst_req", {31'd0, bus.req}, 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rt;
      rt = $urandom & 32'h0000_fffc;
      if ($urandom_range(3) == 0) rt = rt | 32'($urandom_range(3));
      step(($urandom_range(499) == 0), ($urandom_range(2) == 0), ($urandom_range(7) == 0),
           ($urandom_range(9) == 0), ($urandom_range(3) == 0), ($urandom_range(2) != 0),
           $urandom, rt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
